// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES constants, FSM encodings and GF(2^8) helpers for the
// iterative InvSubBytes engine.
package inv_sub_bytes_iter_pkg;

   localparam int AES_BYTE   = 8;
   localparam int AES_DWORD  = 32;
   localparam int AES_LENGTH = 128;
   localparam int AES_NB     = AES_LENGTH / AES_BYTE;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Inverse of the SubBytes affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] s);
      return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
   endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Combinational 8-bit FIPS-197 inverse S-box: undo the affine map, then
// take the field inverse.
module inv_sbox
   import inv_sub_bytes_iter_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = gf_inv(inv_affine(a));

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: captures one 128-bit state, substitutes LANES
// bytes per cycle (lowest bytes first), then presents the result until the
// consumer accepts it.
module inv_sub_bytes_iter
   import inv_sub_bytes_iter_pkg::*;
#(
   parameter int BYTE   = AES_BYTE,
   parameter int LENGTH = AES_LENGTH,
   parameter int LANES  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LENGTH-1:0] inpt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LENGTH-1:0] oupt
);

   localparam int ITER = LENGTH / (BYTE * LANES);
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int LW   = BYTE * LANES;
   localparam logic [LENGTH-1:0] LMASK = {LENGTH{1'b1}} >> (LENGTH - LW);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [LENGTH-1:0] st_q, st_d;

   logic [LENGTH-1:0] window;
   logic [LENGTH-1:0] lane_ext;
   logic [LW-1:0]     lane_in;
   logic [LW-1:0]     lane_out;

   // Select the LANES bytes addressed by count, and place results back there.
   assign window   = st_q >> (count_q * LW);
   assign lane_in  = window[LW-1:0];
   assign lane_ext = LENGTH'(lane_out);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      inv_sbox u_sbox (
         .a (lane_in [g*BYTE +: BYTE]),
         .y (lane_out[g*BYTE +: BYTE])
      );
   end

   // Next-state logic: accept in IDLE, substitute one slice per BUSY cycle,
   // hold the result in DONE until the consumer takes it.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      st_d    = st_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d    = inpt;
               count_d = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            st_d = (st_q & ~(LMASK << (count_q * LW))) | (lane_ext << (count_q * LW));
            if (count_q == CW'(ITER - 1)) begin
               count_d = '0;
               state_d = S_DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         st_q    <= st_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   // Only expose the state once it is fully substituted.
   assign oupt      = out_valid ? st_q : '0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed and round-trip checks for inv_sub_bytes_iter (LANES=4), plus a
// latency/data sweep over LANES=1 and LANES=16 instances.
module tb_inv_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, out_ready;
   logic         in_ready, out_valid;
   logic [127:0] inpt, oupt;

   logic         s_valid, s_or;
   logic [127:0] s_inpt;
   logic         r1, r16, ov1, ov16;
   logic [127:0] o1, o16;

   int total = 0;
   int bad   = 0;

   logic [7:0] fwd [256];

   typedef struct {
      logic [127:0] in;
      logic [127:0] exp;
   } vec_t;
   vec_t vt [4];

   always #5 clk = ~clk;

   inv_sub_bytes_iter #(.LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inpt(inpt), .out_valid(out_valid), .out_ready(out_ready), .oupt(oupt)
   );
   inv_sub_bytes_iter #(.LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r1),
      .inpt(s_inpt), .out_valid(ov1), .out_ready(s_or), .oupt(o1)
   );
   inv_sub_bytes_iter #(.LANES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r16),
      .inpt(s_inpt), .out_valid(ov16), .out_ready(s_or), .oupt(o16)
   );

   // Shift-and-add field multiply, scanning a's bits.
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (a[i]) p ^= bb;
         bb = bb[7] ? ((bb << 1) ^ 8'h1b) : (bb << 1);
      end
      return p;
   endfunction

   // Forward S-box table: brute-force inverse then the forward affine map.
   task automatic build_fwd();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (tb_gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
         fwd[x] = s;
      end
   endtask

   function automatic logic [127:0] sub_bytes(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[x[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Send one block to the LANES=4 engine; return result and cycles to out_valid.
   task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      check("in_ready wait", {127'd0, in_ready}, 128'd1);
      in_valid = 1'b1;
      inpt     = din;
      @(posedge clk); #1;
      in_valid = 1'b0;
      inpt     = rnd128();
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      dout = oupt;
   endtask

   initial begin
      logic [127:0] got, x, held;
      int lat, l1, l16;
      logic [127:0] g1, g16;

      in_valid = 0; out_ready = 1; inpt = '0;
      s_valid = 0; s_or = 1; s_inpt = '0;
      rst_n = 0;
      build_fwd();

      vt[0].in = {16{8'h63}};                        vt[0].exp = '0;
      vt[1].in = '0;                                 vt[1].exp = {16{8'h52}};
      vt[2].in = {8'hed, {14{8'h63}}, 8'h16};        vt[2].exp = {8'h53, {14{8'h00}}, 8'hff};
      vt[3].in = {{15{8'h00}}, 8'h16};               vt[3].exp = {{15{8'h52}}, 8'hff};

      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", {127'd0, in_ready}, 128'd1);
      check("reset out_valid", {127'd0, out_valid}, 128'd0);
      check("reset oupt", oupt, '0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // Directed vectors with fixed latency.
      for (int i = 0; i < 4; i++) begin
         run_block(vt[i].in, got, lat);
         check($sformatf("vec%0d data", i), got, vt[i].exp);
         check($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
      end

      // Round trip, back-to-back with out_ready high.
      for (int i = 0; i < 1000; i++) begin
         x = rnd128();
         run_block(sub_bytes(x), got, lat);
         check("roundtrip", got, x);
      end

      // Backpressure: result held, new requests ignored.
      @(posedge clk); #1;
      out_ready = 1'b0;
      x = rnd128();
      run_block(sub_bytes(x), got, lat);
      check("bp first", got, x);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         inpt     = rnd128();
         @(posedge clk); #1;
         check("bp oupt hold", oupt, x);
         check("bp flags", {125'd0, out_valid, in_ready, 1'b0}, {125'd0, 1'b1, 1'b0, 1'b0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
      x = rnd128();
      run_block(sub_bytes(x), got, lat);
      check("bp after", got, x);

      // Reset in the middle of BUSY (count==2).
      @(posedge clk); #1;
      in_valid = 1'b1;
      inpt     = sub_bytes(rnd128());
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre-abort busy", {127'd0, in_ready}, 128'd0);
      rst_n = 1'b0;
      #1;
      check("abort flags", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
      check("abort oupt", oupt, '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      x = rnd128();
      run_block(sub_bytes(x), got, lat);
      check("post-abort data", got, x);
      check("post-abort latency", 128'(lat), 128'd4);

      // LANES=1 and LANES=16 sweep sharing one input stream.
      for (int i = 0; i < 20; i++) begin
         int n = 0;
         while (!(r1 && r16) && n < 100) begin @(posedge clk); #1; n++; end
         x = rnd128();
         s_inpt  = sub_bytes(x);
         s_valid = 1'b1;
         @(posedge clk); #1;
         s_valid = 1'b0;
         l1 = 0; l16 = 0; g1 = '0; g16 = '0;
         for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ov1 && l1 == 0) begin l1 = c; g1 = o1; end
            if (ov16 && l16 == 0) begin l16 = c; g16 = o16; end
         end
         check("sweep l1 latency", 128'(l1), 128'd16);
         check("sweep l16 latency", 128'(l16), 128'd1);
         check("sweep l1 data", g1, x);
         check("sweep l16 data", g16, x);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
